// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back / write-allocate data cache with true-LRU replacement,
// hit/miss counters and an end-of-program flush of every dirty line.
module cache_assoc_wb #(
    parameter int BIT_W  = 32,
    parameter int ADDR_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_proc_cen,
    input  logic                     i_proc_wen,
    input  logic [ADDR_W-1:0]        i_proc_addr,
    input  logic [BIT_W-1:0]         i_proc_wdata,
    output logic [BIT_W-1:0]         o_proc_rdata,
    output logic                     o_proc_stall,
    input  logic                     i_proc_finish,
    output logic                     o_cache_finish,
    output logic                     o_mem_cen,
    output logic                     o_mem_wen,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [BIT_W*WORDS-1:0]   o_mem_wdata,
    input  logic [BIT_W*WORDS-1:0]   i_mem_rdata,
    input  logic                     i_mem_stall,
    output logic                     o_cache_available,
    input  logic [ADDR_W-1:0]        i_offset,
    output logic [31:0]              o_hit_cnt,
    output logic [31:0]              o_miss_cnt
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_B  = $clog2(SETS);
    localparam int IDX_W  = (IDX_B > 0) ? IDX_B : 1;
    localparam int WAY_B  = $clog2(WAYS);
    localparam int WAY_W  = (WAY_B > 0) ? WAY_B : 1;
    localparam int TAG_W  = ADDR_W - IDX_B - OFF_W - 2;
    localparam int LINE_W = BIT_W * WORDS;
    localparam int LINES  = SETS * WAYS;
    localparam int FL_B   = $clog2(LINES);
    localparam int FL_W   = (FL_B > 0) ? FL_B : 1;
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_WBACK, S_ALLOC, S_FLUSH, S_FLUSH_WR, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];

    logic [WAY_W-1:0]  victim_q;
    logic              retry_q;
    logic [FL_W-1:0]   fl_q;
    logic [31:0]       hit_cnt_q, miss_cnt_q;

    logic [ADDR_W-1:0] real_addr;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_word;
    logic              hit, cmp_hit, vic_found, vic_dirty;
    logic [WAY_W-1:0]  hit_way, victim;
    logic [IDX_W-1:0]  fl_set;
    logic [WAY_W-1:0]  fl_way;
    logic              fl_last, fl_dirty;

    function automatic logic [BIT_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  sel);
        return line[BIT_W*int'(sel) +: BIT_W];
    endfunction

    function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  sel,
                                                   input logic [BIT_W-1:0]  w);
        logic [LINE_W-1:0] r;
        r = line;
        r[BIT_W*int'(sel) +: BIT_W] = w;
        return r;
    endfunction

    // Touched way becomes youngest; only ways younger than its previous age grow older.
    function automatic logic [WAY_W-1:0] next_age(input logic [WAY_W-1:0] cur,
                                                  input logic [WAY_W-1:0] pivot,
                                                  input logic             touched);
        if (touched) return '0;
        if (cur < pivot) return cur + 1'b1;
        return cur;
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                    input logic [IDX_W-1:0] s);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(t) << (ADDR_W - TAG_W);
        if (SETS > 1) a = a | (ADDR_W'(s) << (OFF_W + 2));
        return a;
    endfunction

    assign real_addr = i_proc_addr - i_offset;
    assign req_tag   = TAG_W'(real_addr >> (ADDR_W - TAG_W));
    assign req_idx   = (SETS > 1) ? IDX_W'(real_addr >> (OFF_W + 2)) : '0;
    assign req_word  = OFF_W'(real_addr >> 2);

    assign fl_set   = (SETS > 1) ? IDX_W'(fl_q >> WAY_B) : '0;
    assign fl_way   = (WAYS > 1) ? WAY_W'(fl_q) : '0;
    assign fl_last  = (fl_q == FL_W'(LINES - 1));
    assign fl_dirty = valid_q[fl_set][fl_way] & dirty_q[fl_set][fl_way];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way first, otherwise the oldest way.
    always_comb begin
        victim    = '0;
        vic_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[req_idx][w]) begin
                victim    = WAY_W'(w);
                vic_found = 1'b1;
            end
        end
        if (!vic_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[req_idx][w] == AGE_MAX) victim = WAY_W'(w);
            end
        end
    end

    assign vic_dirty = valid_q[req_idx][victim] & dirty_q[req_idx][victim];
    assign cmp_hit   = (state_q == S_COMPARE) & hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_proc_finish)   state_d = S_FLUSH;
                else if (i_proc_cen) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if (hit)            state_d = S_IDLE;
                else if (vic_dirty) state_d = S_WBACK;
                else                state_d = S_ALLOC;
            end
            S_WBACK:    if (!i_mem_stall) state_d = S_ALLOC;
            S_ALLOC:    if (!i_mem_stall) state_d = S_COMPARE;
            S_FLUSH: begin
                if (fl_dirty)     state_d = S_FLUSH_WR;
                else if (fl_last) state_d = S_DONE;
            end
            S_FLUSH_WR: if (!i_mem_stall) state_d = fl_last ? S_DONE : S_FLUSH;
            S_DONE:     state_d = S_DONE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_cen      = 1'b0;
        o_mem_wen      = 1'b0;
        o_mem_addr     = '0;
        o_mem_wdata    = '0;
        o_proc_rdata   = '0;
        o_proc_stall   = i_proc_cen & ~cmp_hit;
        o_cache_finish = (state_q == S_DONE);
        if (cmp_hit) o_proc_rdata = get_word(data_q[req_idx][hit_way], req_word);
        case (state_q)
            S_WBACK: begin
                o_mem_cen   = 1'b1;
                o_mem_wen   = 1'b1;
                o_mem_addr  = line_addr(tag_q[req_idx][victim_q], req_idx) + i_offset;
                o_mem_wdata = data_q[req_idx][victim_q];
            end
            S_ALLOC: begin
                o_mem_cen  = 1'b1;
                o_mem_addr = line_addr(req_tag, req_idx) + i_offset;
            end
            S_FLUSH_WR: begin
                o_mem_cen   = 1'b1;
                o_mem_wen   = 1'b1;
                o_mem_addr  = line_addr(tag_q[fl_set][fl_way], fl_set) + i_offset;
                o_mem_wdata = data_q[fl_set][fl_way];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    data_q[s][w]  <= '0;
                    tag_q[s][w]   <= '0;
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
            victim_q   <= '0;
            retry_q    <= 1'b0;
            fl_q       <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                S_COMPARE: begin
                    retry_q <= 1'b0;
                    if (hit) begin
                        if (!retry_q) hit_cnt_q <= hit_cnt_q + 32'd1;
                        for (int w = 0; w < WAYS; w++) begin
                            age_q[req_idx][w] <= next_age(age_q[req_idx][w],
                                                          age_q[req_idx][hit_way],
                                                          WAY_W'(w) == hit_way);
                        end
                        if (i_proc_wen) begin
                            data_q[req_idx][hit_way]  <= put_word(data_q[req_idx][hit_way],
                                                                  req_word, i_proc_wdata);
                            dirty_q[req_idx][hit_way] <= 1'b1;
                        end
                    end else begin
                        miss_cnt_q <= miss_cnt_q + 32'd1;
                        victim_q   <= victim;
                    end
                end
                S_ALLOC: begin
                    // A filled way was either invalid or the oldest, so every other way ages.
                    if (!i_mem_stall) begin
                        data_q[req_idx][victim_q]  <= i_mem_rdata;
                        tag_q[req_idx][victim_q]   <= req_tag;
                        valid_q[req_idx][victim_q] <= 1'b1;
                        dirty_q[req_idx][victim_q] <= 1'b0;
                        retry_q                    <= 1'b1;
                        for (int w = 0; w < WAYS; w++) begin
                            age_q[req_idx][w] <= next_age(age_q[req_idx][w], AGE_MAX,
                                                          WAY_W'(w) == victim_q);
                        end
                    end
                end
                S_FLUSH: begin
                    if (!fl_dirty && !fl_last) fl_q <= fl_q + 1'b1;
                end
                S_FLUSH_WR: begin
                    if (!i_mem_stall) begin
                        dirty_q[fl_set][fl_way] <= 1'b0;
                        if (!fl_last) fl_q <= fl_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hit_cnt         = hit_cnt_q;
    assign o_miss_cnt        = miss_cnt_q;
    assign o_cache_available = 1'b1;

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed bench for cache_assoc_wb: 2-way, 4 sets, 4-word lines, memory with 3 stall cycles.
module tb_cache_assoc_wb;

    localparam int BIT_W  = 32;
    localparam int ADDR_W = 32;
    localparam int WORDS  = 4;
    localparam int SETS   = 4;
    localparam int WAYS   = 2;
    localparam int LINE_W = BIT_W * WORDS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              proc_cen, proc_wen, proc_finish;
    logic [ADDR_W-1:0] proc_addr, offset;
    logic [BIT_W-1:0]  proc_wdata, proc_rdata;
    logic              proc_stall, cache_finish, cache_available;
    logic              mem_cen, mem_wen, mem_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;
    logic [31:0]       hit_cnt, miss_cnt;

    int vectors = 0;
    int miscompares = 0;

    cache_assoc_wb #(.BIT_W(BIT_W), .ADDR_W(ADDR_W), .WORDS(WORDS), .SETS(SETS), .WAYS(WAYS)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_proc_cen(proc_cen), .i_proc_wen(proc_wen), .i_proc_addr(proc_addr),
        .i_proc_wdata(proc_wdata), .o_proc_rdata(proc_rdata), .o_proc_stall(proc_stall),
        .i_proc_finish(proc_finish), .o_cache_finish(cache_finish),
        .o_mem_cen(mem_cen), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_stall(mem_stall),
        .o_cache_available(cache_available), .i_offset(offset),
        .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Memory image: word at byte address a reads as 0xC0DE_0000 | a[15:0].
    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < WORDS; k++)
            mem_rdata[k*BIT_W +: BIT_W] = 32'hC0DE_0000 | {16'h0, mem_addr[15:0] + 16'(4*k)};
    end

    int unsigned mem_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst)                      mem_cnt <= 0;
        else if (mem_cen && mem_stall) mem_cnt <= mem_cnt + 1;
        else                          mem_cnt <= 0;
    end
    assign mem_stall = !(mem_cen && mem_cnt == 3);

    int                wr_cnt = 0;
    int                rd_cnt = 0;
    int                cen_cyc = 0;
    logic [31:0]       last_rd_addr = '0;
    logic [31:0]       wr_addr_q[$];
    logic [LINE_W-1:0] wr_data_q[$];

    always @(posedge clk) begin
        if (mem_cen) cen_cyc <= cen_cyc + 1;
        if (mem_cen && !mem_stall) begin
            if (mem_wen) begin
                wr_cnt <= wr_cnt + 1;
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end else begin
                rd_cnt       <= rd_cnt + 1;
                last_rd_addr <= mem_addr;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU access; returns data and the number of cycles until stall dropped.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int cyc);
        proc_cen   = 1'b1;
        proc_wen   = w;
        proc_addr  = a;
        proc_wdata = d;
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end while (proc_stall && cyc < 200);
        rd = proc_rdata;
        proc_cen = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] rd;
    int          cyc, w0, r0, c0, n;

    initial begin
        proc_cen    = 1'b0;
        proc_wen    = 1'b0;
        proc_addr   = '0;
        proc_wdata  = '0;
        proc_finish = 1'b0;
        offset      = 32'h0001_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_finish", cache_finish, 0);
        chk("rst_mem_cen", mem_cen, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_rdata", proc_rdata, 0);
        chk("rst_hits", hit_cnt, 0);
        chk("rst_misses", miss_cnt, 0);
        chk("available", cache_available, 1);
        @(negedge clk);

        // Cold read miss fills line 0x10000
        r0 = rd_cnt;
        access(1'b0, 32'h0001_0004, 0, rd, cyc);
        chk("t1_cycles", cyc, 6);
        chk("t1_rdata", rd, 32'hC0DE_0004);
        chk("t1_fills", rd_cnt - r0, 1);
        chk("t1_fill_addr", last_rd_addr, 32'h0001_0000);
        chk("t1_misses", miss_cnt, 1);
        chk("t1_hits", hit_cnt, 0);

        // Write hit then read hit, no memory traffic
        c0 = cen_cyc;
        access(1'b1, 32'h0001_0008, 32'hDEAD_BEEF, rd, cyc);
        chk("t2_wr_cycles", cyc, 1);
        access(1'b0, 32'h0001_0008, 0, rd, cyc);
        chk("t2_rd_cycles", cyc, 1);
        chk("t2_rdata", rd, 32'hDEAD_BEEF);
        chk("t2_no_mem", cen_cyc - c0, 0);
        chk("t2_hits", hit_cnt, 2);
        chk("t2_misses", miss_cnt, 1);

        // LRU picks the clean 0x10040 way; 0x10000 survives
        access(1'b0, 32'h0001_0000, 0, rd, cyc);
        chk("t3_touch0", cyc, 1);
        access(1'b0, 32'h0001_0040, 0, rd, cyc);
        chk("t3_fill40_cycles", cyc, 6);
        chk("t3_fill40_rdata", rd, 32'hC0DE_0040);
        access(1'b0, 32'h0001_0000, 0, rd, cyc);
        chk("t3_retouch0", cyc, 1);
        w0 = wr_cnt;
        access(1'b0, 32'h0001_0080, 0, rd, cyc);
        chk("t3_fill80_cycles", cyc, 6);
        chk("t3_fill80_rdata", rd, 32'hC0DE_0080);
        chk("t3_fill80_addr", last_rd_addr, 32'h0001_0080);
        chk("t3_no_wback", wr_cnt - w0, 0);
        access(1'b0, 32'h0001_0000, 0, rd, cyc);
        chk("t3_keep0_cycles", cyc, 1);
        chk("t3_keep0_rdata", rd, 32'hC0DE_0000);
        chk("t3_hits", hit_cnt, 5);
        chk("t3_misses", miss_cnt, 3);

        // Dirty LRU victim is written back before the fill
        access(1'b1, 32'h0001_000C, 32'h1234_5678, rd, cyc);
        chk("t4_dirty_cycles", cyc, 1);
        access(1'b0, 32'h0001_0040, 0, rd, cyc);
        chk("t4_fill40_cycles", cyc, 6);
        access(1'b0, 32'h0001_0040, 0, rd, cyc);
        chk("t4_touch40", cyc, 1);
        w0 = wr_cnt;
        access(1'b0, 32'h0001_0080, 0, rd, cyc);
        chk("t4_wb_cycles", cyc, 10);
        chk("t4_rdata", rd, 32'hC0DE_0080);
        chk("t4_wb_count", wr_cnt - w0, 1);
        chk("t4_wb_addr", wr_addr_q[w0], 32'h0001_0000);
        chk("t4_wb_data", wr_data_q[w0], 128'h12345678_DEADBEEF_C0DE0004_C0DE0000);
        chk("t4_fill_addr", last_rd_addr, 32'h0001_0080);
        chk("t4_hits", hit_cnt, 7);
        chk("t4_misses", miss_cnt, 5);

        // Two write misses leave two dirty lines, then flush
        access(1'b1, 32'h0001_0010, 32'hA5A5_A5A5, rd, cyc);
        chk("t5_wmiss1_cycles", cyc, 6);
        access(1'b1, 32'h0001_0024, 32'h5A5A_5A5A, rd, cyc);
        chk("t5_wmiss2_cycles", cyc, 6);
        chk("t5_hits", hit_cnt, 7);
        chk("t5_misses", miss_cnt, 7);
        w0 = wr_cnt;
        proc_finish = 1'b1;
        n = 0;
        while (!cache_finish && n < 500) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("t5_finish", cache_finish, 1);
        chk("t5_flush_count", wr_cnt - w0, 2);
        chk("t5_flush_addr0", wr_addr_q[w0], 32'h0001_0010);
        chk("t5_flush_data0", wr_data_q[w0], 128'hC0DE001C_C0DE0018_C0DE0014_A5A5A5A5);
        chk("t5_flush_addr1", wr_addr_q[w0+1], 32'h0001_0020);
        chk("t5_flush_data1", wr_data_q[w0+1], 128'hC0DE002C_C0DE0028_5A5A5A5A_C0DE0020);
        proc_finish = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_finish_sticky", cache_finish, 1);
        chk("t5_done_mem_cen", mem_cen, 0);
        chk("t5_no_extra_wr", wr_cnt - w0, 2);

        // Reset in the middle of a fill
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_finish_clr", cache_finish, 0);
        proc_cen  = 1'b1;
        proc_wen  = 1'b0;
        proc_addr = 32'h0001_0004;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t6_alloc_cen", mem_cen, 1);
        chk("t6_alloc_miss", miss_cnt, 1);
        rst = 1'b1;
        #1;
        chk("t6_abort_cen", mem_cen, 0);
        chk("t6_abort_misses", miss_cnt, 0);
        chk("t6_abort_hits", hit_cnt, 0);
        proc_cen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(1'b0, 32'h0001_0004, 0, rd, cyc);
        chk("t6_cold_cycles", cyc, 6);
        chk("t6_cold_rdata", rd, 32'hC0DE_0004);
        access(1'b0, 32'h0001_0080, 0, rd, cyc);
        chk("t6_invalid80", cyc, 6);
        chk("t6_misses", miss_cnt, 2);
        chk("t6_hits", hit_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
